pipe_exe_stage: RTL and testbench

PIPE_EXE_STAGE -- requirements
Module: pipe_exe_stage

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_muldiv.sv | 116 +++++++++++
 rtl/pipe_exe_stage.sv | 66 ++++++
 tb/tb_pipe_exe_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the execute stage: ALU op codes, mul/div and mfhi/mflo
// selects, engine states and the datapath width.
package pipe_pkg;

    localparam int unsigned WIDTH = 32;

    // ALU op decoded on ealuc[2:0]; ealuc[3] only separates srl from sra.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRX = 3'b111;

    typedef enum logic [1:0] {MD_NONE, MD_MULT, MD_DIV, MD_RSVD} muldiv_e;
    typedef enum logic [1:0] {MF_ALU, MF_HI, MF_LO, MF_RSVD} mfhilo_e;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} md_state_e;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/pipe_muldiv.sv
// Iterative 32-cycle signed multiply / divide engine owning HI and LO.
// Divide support is built only when PIPE_EXE_DIV_EN is defined.
module pipe_muldiv import pipe_pkg::*; (
    input  logic             clock,
    input  logic             resetn,
    input  logic             bubble_i,
    input  logic [1:0]       muldiv_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             stall_o,
    output logic             busy_o
);
    md_state_e        state_q;
    logic [4:0]       cnt_q;
    logic [WIDTH-1:0] a_q, hi_q, lo_q;
    logic             neg_q;
    logic [63:0]      prod_q;
    muldiv_e          op;
    logic             go, go_div;
    logic [WIDTH-1:0] md, hi_d, lo_d;
    logic [32:0]      sum;
    logic [63:0]      mul_nxt, mul_res, step;
`ifdef PIPE_EXE_DIV_EN
    logic             div_q;
    logic [WIDTH-1:0] b_q, quo, rem;
    logic [32:0]      trial;
    logic [63:0]      div_nxt;
`endif

    assign op = muldiv_e'(muldiv_i);

    // prod_q holds {acc, multiplier} for mult and {remainder, quotient} for div,
    // both on magnitudes; signs are applied once on the final iteration.
    always_comb begin
        go_div = 1'b0;
`ifdef PIPE_EXE_DIV_EN
        go_div = (op == MD_DIV);
`endif
        go      = resetn && !bubble_i && ((op == MD_MULT) || go_div);
        md      = mag(a_q);
`ifdef PIPE_EXE_DIV_EN
        if (div_q) md = mag(b_q);
`endif
        sum     = {1'b0, prod_q[63:32]} + {1'b0, md};
        mul_nxt = prod_q[0] ? {sum, prod_q[31:1]} : {1'b0, prod_q[63:1]};
        mul_res = neg_q ? -mul_nxt : mul_nxt;
        step    = mul_nxt;
        hi_d    = mul_res[63:32];
        lo_d    = mul_res[31:0];
`ifdef PIPE_EXE_DIV_EN
        trial   = prod_q[63:31] - {1'b0, md};
        div_nxt = trial[32] ? {prod_q[62:0], 1'b0} : {trial[31:0], prod_q[30:0], 1'b1};
        quo     = div_nxt[31:0];
        rem     = div_nxt[63:32];
        if (div_q) begin
            step = div_nxt;
            if (b_q == '0) begin
                hi_d = a_q;
                lo_d = '1;
            end else begin
                hi_d = a_q[WIDTH-1] ? -rem : rem;
                lo_d = neg_q ? -quo : quo;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef PIPE_EXE_DIV_EN
            div_q   <= 1'b0;
            b_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (go) begin
                    state_q <= ST_BUSY;
                    cnt_q   <= '0;
                    a_q     <= a_i;
                    neg_q   <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                    prod_q  <= {32'b0, mag(b_i)};
`ifdef PIPE_EXE_DIV_EN
                    b_q     <= b_i;
                    div_q   <= go_div;
                    if (go_div) prod_q <= {32'b0, mag(a_i)};
`endif
                end
                ST_BUSY: begin
                    prod_q <= step;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= ST_DONE;
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall_o = ((state_q == ST_IDLE) && go) || (state_q == ST_BUSY);
    assign busy_o  = (state_q != ST_IDLE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: rtl/pipe_exe_stage.sv
// Execute stage: operand select, combinational ALU, result mux and the
// iterative mul/div engine. Define PIPE_EXE_DIV_EN to enable signed divide.
module pipe_exe_stage import pipe_pkg::*; (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ebubble,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic [WIDTH-1:0] eimm,
    input  logic [WIDTH-1:0] esa,
    input  logic [WIDTH-1:0] epc4,
    input  logic [3:0]       ealuc,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic             ejal,
    input  logic [1:0]       emuldiv,
    input  logic [1:0]       emfhilo,
    output logic [WIDTH-1:0] ealu,
    output logic             estall,
    output logic             ebusy
);
    logic [WIDTH-1:0] opa, opb, alu_r, hi, lo;
    logic signed [WIDTH-1:0] opb_s;
    mfhilo_e mf;

    pipe_muldiv u_muldiv (
        .clock    (clock),
        .resetn   (resetn),
        .bubble_i (ebubble),
        .muldiv_i (emuldiv),
        .a_i      (ea),
        .b_i      (eb),
        .hi_o     (hi),
        .lo_o     (lo),
        .stall_o  (estall),
        .busy_o   (ebusy)
    );

    assign opa   = eshift ? esa : ea;
    assign opb   = ealuimm ? eimm : eb;
    assign opb_s = opb;
    assign mf    = mfhilo_e'(emfhilo);

    always_comb begin
        alu_r = '0;
        case (ealuc[2:0])
            ALU_ADD: alu_r = opa + opb;
            ALU_SUB: alu_r = opa - opb;
            ALU_AND: alu_r = opa & opb;
            ALU_OR:  alu_r = opa | opb;
            ALU_XOR: alu_r = opa ^ opb;
            ALU_LUI: alu_r = opb << 16;
            ALU_SLL: alu_r = opb << opa[4:0];
            ALU_SRX: alu_r = ealuc[3] ? WIDTH'(opb_s >>> opa[4:0]) : (opb >> opa[4:0]);
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        if (ejal)             ealu = epc4 + 32'd4;
        else if (mf == MF_HI) ealu = hi;
        else if (mf == MF_LO) ealu = lo;
        else                  ealu = alu_r;
    end

endmodule

// File: tb/tb_pipe_exe_stage.sv
// Randomized self-checking bench for pipe_exe_stage against an arithmetic
// reference model; divide expectations follow PIPE_EXE_DIV_EN.
module tb_pipe_exe_stage;

    logic        clock = 1'b0;
    logic        resetn, ebubble, ealuimm, eshift, ejal;
    logic [31:0] ea, eb, eimm, esa, epc4, ealu;
    logic [3:0]  ealuc;
    logic [1:0]  emuldiv, emfhilo;
    logic        estall, ebusy;

`ifdef PIPE_EXE_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [3:0]  codes [9] = '{4'd0, 4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd15};

    always #5 clock = ~clock;

    pipe_exe_stage dut (
        .clock(clock), .resetn(resetn), .ebubble(ebubble), .ea(ea), .eb(eb),
        .eimm(eimm), .esa(esa), .epc4(epc4), .ealuc(ealuc), .ealuimm(ealuimm),
        .eshift(eshift), .ejal(ejal), .emuldiv(emuldiv), .emfhilo(emfhilo),
        .ealu(ealu), .estall(estall), .ebusy(ebusy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sb;
        sb = b;
        case (op)
            4'd0, 4'd8:  return a + b;
            4'd4, 4'd12: return a - b;
            4'd1, 4'd9:  return a & b;
            4'd5, 4'd13: return a | b;
            4'd2, 4'd10: return a ^ b;
            4'd6, 4'd14: return {b[15:0], 16'h0000};
            4'd3:        return b << a[4:0];
            4'd7:        return b >> a[4:0];
            4'd15:       return sb >>> a[4:0];
            default:     return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_ealu();
        logic [31:0] a, b;
        a = eshift ? esa : ea;
        b = ealuimm ? eimm : eb;
        if (ejal) return epc4 + 32'd4;
        if (emfhilo == 2'b01) return m_hi;
        if (emfhilo == 2'b10) return m_lo;
        return ref_alu(ealuc, a, b);
    endfunction

    task automatic md_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b01) begin
            p = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b == 32'h0) begin
            m_hi = a;
            m_lo = 32'hFFFF_FFFF;
        end else begin
            q = sa / sb;
            r = sa % sb;
            m_hi = r[31:0];
            m_lo = q[31:0];
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one mul/div from IDLE, count stall cycles, check HI/LO in DONE.
    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic bub, output int stalls);
        bit active;
        active  = !bub && (op == 2'b01 || (DIV_ON && op == 2'b10));
        ea = a; eb = b; emuldiv = op; ebubble = bub; emfhilo = 2'b00; ejal = 1'b0;
        stalls = 0;
        #1;
        while (estall === 1'b1 && stalls < 100) begin
            stalls++;
            @(posedge clock);
            #2;
        end
        check("stall_len", 32'(stalls), active ? 32'd33 : 32'd0);
        if (active) md_model(op, a, b);
        check("busy_done", {31'b0, ebusy}, {31'b0, active});
        emfhilo = 2'b01; #1;
        check("mfhi", ealu, m_hi);
        emfhilo = 2'b10; #1;
        check("mflo", ealu, m_lo);
        emfhilo = 2'b00;
        step();
        check("no_restart", {31'b0, ebusy}, 32'd0);
        emuldiv = 2'b00; ebubble = 1'b0; #1;
        check("idle_stall", {31'b0, estall}, 32'd0);
    endtask

    initial begin
        int s1, s2;
        logic [1:0] op;
        logic [31:0] a, b;
        resetn = 1'b0; ebubble = 1'b0; ea = '0; eb = '0; eimm = '0; esa = '0;
        epc4 = '0; ealuc = '0; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0;
        emuldiv = 2'b00; emfhilo = 2'b00;
        #2;
        check("rst_stall", {31'b0, estall}, 32'd0);
        check("rst_busy", {31'b0, ebusy}, 32'd0);
        emfhilo = 2'b01; #1; check("rst_hi", ealu, 32'h0);
        emfhilo = 2'b10; #1; check("rst_lo", ealu, 32'h0);
        emfhilo = 2'b00;
        step();
        resetn = 1'b1;
        step();

        ea = 32'h7FFF_FFFF; eb = 32'h1; ealuc = 4'b0000; #1;
        check("add_wrap", ealu, 32'h8000_0000);
        check("add_stall", {31'b0, estall}, 32'd0);
        eshift = 1'b1; esa = 32'd4; ealuc = 4'b1111; eb = 32'hF000_0000; #1;
        check("sra", ealu, 32'hFF00_0000);
        ejal = 1'b1; epc4 = 32'h100; #1;
        check("jal", ealu, 32'h104);
        ejal = 1'b0; eshift = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ea = $urandom; eb = $urandom; eimm = $urandom; esa = $urandom_range(0, 31);
            epc4 = $urandom; ealuc = codes[$urandom_range(0, 8)];
            ealuimm = 1'($urandom); eshift = 1'($urandom); ejal = ($urandom_range(0, 7) == 0);
            emfhilo = 2'($urandom);
            #2;
            check("alu_rand", ealu, ref_ealu());
            if (i % 8 == 0) check("alu_stall", {31'b0, estall}, 32'd0);
        end
        ejal = 1'b0; eshift = 1'b0; ealuimm = 1'b0; emfhilo = 2'b00;
        step();

        run_md(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, s1);
        check("mult_lo_const", m_lo, 32'hFFFF_FFFA);
        run_md(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, s1);
        run_md(2'b10, 32'd5, 32'd0, 1'b0, s1);
        run_md(2'b01, 32'h1234_5678, 32'h8765_4321, 1'b1, s1);

        run_md(2'b01, 32'h0001_0003, 32'hFFFF_0005, 1'b0, s1);
        run_md(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, s2);
        check("b2b_total", 32'(s1 + s2), 32'd66);

        for (int i = 0; i < 8; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom_range(0, 1) == 0 ? $urandom : 32'($urandom_range(1, 100)));
            run_md(op, a, b, 1'b0, s1);
        end
        run_md(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, s1);

        ea = 32'h0000_0123; eb = 32'h0000_0456; emuldiv = 2'b01; ebubble = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("busy_pre_rst", {31'b0, estall}, 32'd1);
        resetn = 1'b0; #1;
        m_hi = '0; m_lo = '0;
        check("abort_stall", {31'b0, estall}, 32'd0);
        check("abort_busy", {31'b0, ebusy}, 32'd0);
        emfhilo = 2'b01; #1; check("abort_hi", ealu, m_hi);
        emfhilo = 2'b10; #1; check("abort_lo", ealu, m_lo);
        emfhilo = 2'b00; emuldiv = 2'b00;
        step();
        resetn = 1'b1;
        step();
        run_md(2'b01, 32'd6, 32'd7, 1'b0, s1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
